fb_sram_arbiter: RTL and testbench

Frame-buffer SRAM arbiter and sequencer between the HDMI transmitter's pixel-fetch port and the image-producer write port. Serialises all accesses to the single external 24-bit SRAM. Reads always take priority because the display path is hard real-time. Maintains the front/back bank bit so that writes always land in the bank not being displayed, and returns fetched pixels to the transmitter as a registered data line with a one-cycle valid strobe.

---
 rtl/fb_sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_fb_sram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sram_arbiter.sv
// Frame-buffer SRAM arbiter: serialises display reads (priority) and producer writes
// onto one external 24-bit SRAM and tracks the front/back bank bit.
module fb_sram_arbiter #(
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [19:0] rd_addr,
  output logic        rd_valid,
  output logic [23:0] rd_data,
  output logic        rd_overrun,
  input  logic        wr_req,
  input  logic [18:0] wr_addr,
  input  logic [23:0] wr_data,
  output logic        wr_ack,
  output logic        wr_starved,
  input  logic        frame_swap,
  output logic        front_bank,
  output logic [19:0] sram_addr,
  output logic [23:0] sram_wdata,
  input  logic [23:0] sram_rdata,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_SETUP, WR_STROBE} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic [19:0]      pend_addr, pend_addr_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             rd_valid_nxt, rd_overrun_nxt, wr_ack_nxt, wr_starved_nxt, front_bank_nxt;
  logic [23:0]      rd_data_nxt, sram_wdata_nxt;
  logic [19:0]      sram_addr_nxt;
  logic             sram_ce_nxt, sram_oe_nxt, sram_we_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      rd_pend    <= 1'b0;
      pend_addr  <= '0;
      starve_cnt <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_overrun <= 1'b0;
      wr_ack     <= 1'b0;
      wr_starved <= 1'b0;
      front_bank <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_we    <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      rd_pend    <= rd_pend_nxt;
      pend_addr  <= pend_addr_nxt;
      starve_cnt <= starve_cnt_nxt;
      rd_valid   <= rd_valid_nxt;
      rd_data    <= rd_data_nxt;
      rd_overrun <= rd_overrun_nxt;
      wr_ack     <= wr_ack_nxt;
      wr_starved <= wr_starved_nxt;
      front_bank <= front_bank_nxt;
      sram_addr  <= sram_addr_nxt;
      sram_wdata <= sram_wdata_nxt;
      sram_ce    <= sram_ce_nxt;
      sram_oe    <= sram_oe_nxt;
      sram_we    <= sram_we_nxt;
    end
  end

  // Next state; strobes are computed for the state being entered
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    rd_pend_nxt    = rd_pend;
    pend_addr_nxt  = pend_addr;
    rd_overrun_nxt = rd_overrun;
    rd_valid_nxt   = 1'b0;
    rd_data_nxt    = rd_data;
    wr_ack_nxt     = 1'b0;
    sram_addr_nxt  = sram_addr;
    sram_wdata_nxt = sram_wdata;
    sram_ce_nxt    = 1'b0;
    sram_oe_nxt    = 1'b0;
    sram_we_nxt    = 1'b0;
    front_bank_nxt = front_bank ^ frame_swap;

    if (rd_req) begin
      pend_addr_nxt = rd_addr;
      rd_pend_nxt   = 1'b1;
      if (rd_pend) rd_overrun_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (rd_req || rd_pend) begin
          state_nxt     = RD_ISSUE;
          sram_ce_nxt   = 1'b1;
          sram_oe_nxt   = 1'b1;
          sram_addr_nxt = rd_req ? rd_addr : pend_addr;
          rd_pend_nxt   = 1'b0;
        end else if (wr_req) begin
          state_nxt      = WR_SETUP;
          sram_ce_nxt    = 1'b1;
          sram_addr_nxt  = {~front_bank, wr_addr};
          sram_wdata_nxt = wr_data;
        end
      end
      RD_ISSUE: begin
        state_nxt   = RD_WAIT;
        sram_ce_nxt = 1'b1;
        sram_oe_nxt = 1'b1;
        lat_cnt_nxt = LAT_W'(READ_LAT);
      end
      RD_WAIT: begin
        lat_cnt_nxt = lat_cnt - LAT_W'(1);
        if (lat_cnt == LAT_W'(1)) begin
          state_nxt    = IDLE;
          rd_valid_nxt = 1'b1;
          rd_data_nxt  = sram_rdata;
        end else begin
          sram_ce_nxt = 1'b1;
          sram_oe_nxt = 1'b1;
        end
      end
      WR_SETUP: begin
        state_nxt   = WR_STROBE;
        sram_ce_nxt = 1'b1;
        sram_we_nxt = 1'b1;
        wr_ack_nxt  = 1'b1;
      end
      WR_STROBE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase

    // Write wait counter: frozen while the write is on the pins, cleared on commit
    starve_cnt_nxt = starve_cnt;
    if (!wr_req || state == WR_STROBE) begin
      starve_cnt_nxt = '0;
    end else if (state != WR_SETUP && starve_cnt != '1) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
    wr_starved_nxt = (starve_cnt_nxt >= CNT_W'(STARVE_LIM));
  end

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Bench for fb_sram_arbiter: timeline-reservation model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fb_sram_arbiter;

  localparam int RL = 2;
  localparam int SL = 4;
  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        rst, rd_req, wr_req, frame_swap;
  logic [19:0] rd_addr;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        rd_valid, rd_overrun, wr_ack, wr_starved, front_bank;
  logic [23:0] rd_data, sram_wdata, sram_rdata;
  logic [19:0] sram_addr;
  logic        sram_ce, sram_oe, sram_we;

  int n_tests = 0;
  int n_fail  = 0;

  fb_sram_arbiter #(.READ_LAT(RL), .STARVE_LIM(SL)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_overrun(rd_overrun),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_starved(wr_starved),
    .frame_swap(frame_swap), .front_bank(front_bank),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce(sram_ce), .sram_oe(sram_oe), .sram_we(sram_we)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] sram_fn(input logic [19:0] a);
    if (a == 20'h80010) return 24'hA5C3E1;
    return {4'h0, a} ^ 24'h5A5A5A;
  endfunction

  // SRAM: data valid only once oe has been held READ_LAT cycles
  int unsigned oe_age = 0;
  always @(posedge clk) oe_age <= (sram_oe === 1'b1) ? oe_age + 1 : 0;
  assign sram_rdata = (sram_oe === 1'b1 && oe_age >= RL) ? sram_fn(sram_addr) : 24'hDEAD00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected-output timeline, indexed by cycle number modulo RS
  int          cyc = 0;
  bit          e_ce [RS], e_oe [RS], e_we [RS], e_val [RS], e_ack [RS], e_rstf [RS];
  bit          e_starv [RS], e_bank [RS], e_ovr [RS];
  logic [19:0] e_addr [RS];
  logic [23:0] e_wd [RS], e_rd [RS];

  int          m_cnt = 0, m_free = 0, m_wsetup = -10;
  bit          m_pend = 0, m_ovr = 0, m_bank = 0;
  logic [19:0] m_paddr = '0;

  // Model: an access granted in a free cycle reserves the following cycles
  initial forever begin : model
    int          s, d;
    logic [19:0] a;
    @(posedge clk);
    s = cyc % RS;
    e_ce[s] = 0; e_oe[s] = 0; e_we[s] = 0; e_val[s] = 0; e_ack[s] = 0; e_rstf[s] = 0;
    if (rst) begin
      for (int i = 0; i < RS; i++) begin
        e_ce[i] = 0; e_oe[i] = 0; e_we[i] = 0; e_val[i] = 0; e_ack[i] = 0; e_rstf[i] = 0;
      end
      m_pend = 0; m_ovr = 0; m_bank = 0; m_cnt = 0; m_free = cyc + 1; m_wsetup = -10;
      e_rstf[(cyc + 1) % RS] = 1;
    end else begin
      if (!wr_req || cyc == m_wsetup + 1) m_cnt = 0;
      else if (cyc != m_wsetup && m_cnt < 255) m_cnt++;
      if (cyc >= m_free) begin
        if (rd_req || m_pend) begin
          a = rd_req ? rd_addr : m_paddr;
          if (rd_req && m_pend) m_ovr = 1;
          m_pend = 0;
          for (int k = 1; k <= RL + 1; k++) begin
            d = (cyc + k) % RS;
            e_ce[d] = 1; e_oe[d] = 1; e_addr[d] = a;
          end
          d = (cyc + RL + 2) % RS;
          e_val[d] = 1; e_rd[d] = sram_fn(a);
          m_free = cyc + RL + 2;
        end else if (wr_req) begin
          a = {~m_bank, wr_addr};
          for (int k = 1; k <= 2; k++) begin
            d = (cyc + k) % RS;
            e_ce[d] = 1; e_addr[d] = a; e_wd[d] = wr_data;
          end
          d = (cyc + 2) % RS;
          e_we[d] = 1; e_ack[d] = 1;
          m_wsetup = cyc + 1;
          m_free = cyc + 3;
        end
      end else if (rd_req) begin
        if (m_pend) m_ovr = 1;
        m_pend = 1; m_paddr = rd_addr;
      end
      m_bank = m_bank ^ frame_swap;
    end
    d = (cyc + 1) % RS;
    e_starv[d] = (m_cnt >= SL); e_bank[d] = m_bank; e_ovr[d] = m_ovr;
    cyc++;
  end

  // Compare every cycle once the first reset has taken effect
  bit          live = 0;
  logic [23:0] cur_rd = '0;
  initial forever begin : compare
    int s;
    @(negedge clk);
    s = cyc % RS;
    if (e_rstf[s]) begin live = 1; cur_rd = '0; end
    if (live) begin
      if (e_val[s]) cur_rd = e_rd[s];
      chk("m_ce",      32'(sram_ce),    32'(e_ce[s]));
      chk("m_oe",      32'(sram_oe),    32'(e_oe[s]));
      chk("m_we",      32'(sram_we),    32'(e_we[s]));
      chk("m_rd_valid", 32'(rd_valid),  32'(e_val[s]));
      chk("m_rd_data", 32'(rd_data),    32'(cur_rd));
      chk("m_wr_ack",  32'(wr_ack),     32'(e_ack[s]));
      chk("m_starved", 32'(wr_starved), 32'(e_starv[s]));
      chk("m_bank",    32'(front_bank), 32'(e_bank[s]));
      chk("m_overrun", 32'(rd_overrun), 32'(e_ovr[s]));
      if (e_ce[s]) chk("m_addr", 32'(sram_addr), 32'(e_addr[s]));
      if (e_ce[s] && !e_oe[s]) chk("m_wdata", 32'(sram_wdata), 32'(e_wd[s]));
    end
  end

  initial begin : stim
    bit got;
    rst = 1; rd_req = 0; wr_req = 0; frame_swap = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    rst = 0;
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_ce",       32'(sram_ce),  32'h0);
    chk("rst_addr",     32'(sram_addr), 32'h0);
    chk("rst_rd_data",  32'(rd_data),  32'h0);
    chk("rst_bank",     32'(front_bank), 32'h0);
    tick();

    // Uncontended read
    rd_req = 1; rd_addr = 20'h80010;
    tick(); rd_req = 0;
    chk("r1_oe_t1", 32'(sram_oe), 32'h1);
    chk("r1_addr",  32'(sram_addr), 32'h80010);
    tick(); chk("r1_oe_t2", 32'(sram_oe), 32'h1);
    tick(); chk("r1_oe_t3", 32'(sram_oe), 32'h1);
    tick();
    chk("r1_valid",   32'(rd_valid), 32'h1);
    chk("r1_data",    32'(rd_data),  32'hA5C3E1);
    chk("r1_overrun", 32'(rd_overrun), 32'h0);
    chk("r1_oe_t4",   32'(sram_oe), 32'h0);
    tick();

    // Uncontended write into back bank 1
    wr_req = 1; wr_addr = 19'h00123; wr_data = 24'h112233;
    tick();
    chk("w1_addr_t1",  32'(sram_addr), 32'h80123);
    chk("w1_wdata_t1", 32'(sram_wdata), 32'h112233);
    chk("w1_we_t1",    32'(sram_we), 32'h0);
    tick();
    chk("w1_we_t2",  32'(sram_we), 32'h1);
    chk("w1_ack_t2", 32'(wr_ack), 32'h1);
    chk("w1_addr_t2", 32'(sram_addr), 32'h80123);
    wr_req = 0;
    tick(); chk("w1_ce_t3", 32'(sram_ce), 32'h0);
    tick();

    // Simultaneous read and write: read first
    rd_req = 1; rd_addr = 20'h00300;
    wr_req = 1; wr_addr = 19'h00007; wr_data = 24'hABCDEF;
    tick(); rd_req = 0;
    repeat (3) tick();
    chk("rw_valid_t4", 32'(rd_valid), 32'h1);
    tick();
    chk("rw_setup_t5", 32'({sram_ce, sram_oe, sram_we}), 32'h4);
    tick();
    chk("rw_ack_t6", 32'(wr_ack), 32'h1);
    wr_req = 0;
    repeat (2) tick();

    // Two reads one cycle apart; second served at first+8
    rd_req = 1; rd_addr = 20'h00011;
    tick(); rd_addr = 20'h00042;
    tick(); rd_req = 0;
    repeat (2) tick();
    chk("rr_valid1", 32'(rd_valid), 32'h1);
    repeat (3) tick();
    chk("rr_novalid7", 32'(rd_valid), 32'h0);
    tick();
    chk("rr_valid2", 32'(rd_valid), 32'h1);
    chk("rr_data2",  32'(rd_data), 32'h5A5A18);
    chk("rr_no_ovr", 32'(rd_overrun), 32'h0);
    tick();

    // Three consecutive pulses overrun the pending register
    rd_req = 1; rd_addr = 20'h00001;
    tick(); rd_addr = 20'h00002;
    tick(); rd_addr = 20'h00003;
    chk("ovr_before", 32'(rd_overrun), 32'h0);
    tick(); rd_req = 0;
    chk("ovr_set", 32'(rd_overrun), 32'h1);
    repeat (10) tick();
    chk("ovr_sticky", 32'(rd_overrun), 32'h1);

    // Held write starved by reads every 3 cycles
    wr_req = 1; wr_addr = 19'h00abc; wr_data = 24'h0c0ffe;
    for (int k = 0; k < 18; k++) begin
      rd_req = (k % 3 == 0);
      rd_addr = 20'h00100 + 20'(k);
      tick();
      if (k + 1 == 3) chk("st_low_w3",  32'(wr_starved), 32'h0);
      if (k + 1 == 4) chk("st_high_w4", 32'(wr_starved), 32'h1);
    end
    rd_req = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (wr_ack) got = 1;
      else tick();
    end
    chk("st_ack_seen", 32'(got), 32'h1);
    chk("st_at_ack", 32'(wr_starved), 32'h1);
    wr_req = 0;
    tick();
    chk("st_cleared", 32'(wr_starved), 32'h0);

    // Frame swap then write lands in bank 0
    frame_swap = 1;
    tick(); frame_swap = 0;
    chk("fs_bank1", 32'(front_bank), 32'h1);
    wr_req = 1; wr_addr = 19'h00456; wr_data = 24'h000456;
    tick();
    chk("fs_addr", 32'(sram_addr), 32'h00456);
    tick();
    chk("fs_ack", 32'(wr_ack), 32'h1);
    wr_req = 0;
    tick();

    // Swap coinciding with write setup: write keeps the pre-toggle back bank
    frame_swap = 1; wr_req = 1; wr_addr = 19'h00789; wr_data = 24'h000789;
    tick(); frame_swap = 0;
    chk("fsw_addr", 32'(sram_addr), 32'h00789);
    chk("fsw_bank", 32'(front_bank), 32'h0);
    tick();
    chk("fsw_ack", 32'(wr_ack), 32'h1);
    wr_req = 0;
    tick();

    // Reset during RD_WAIT aborts the read
    rd_req = 1; rd_addr = 20'h00500;
    tick(); rd_req = 0;
    tick(); rst = 1;
    tick(); rst = 0;
    chk("ra_strobes", 32'({sram_ce, sram_oe, sram_we}), 32'h0);
    chk("ra_valid",   32'(rd_valid), 32'h0);
    chk("ra_overrun", 32'(rd_overrun), 32'h0);
    tick();
    chk("ra_novalid", 32'(rd_valid), 32'h0);
    tick();
    rd_req = 1; rd_addr = 20'h80010;
    tick(); rd_req = 0;
    repeat (3) tick();
    chk("ra_fresh_valid", 32'(rd_valid), 32'h1);
    chk("ra_fresh_data",  32'(rd_data), 32'hA5C3E1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
